// File: rtl/sprite_line_scheduler_pkg.sv
// Shared timing constants, ROM address field widths and scheduler state encoding
// for the sprite line scheduler and its pixel mux.
package sprite_line_scheduler_pkg;
    localparam int H_DISPLAY = 256;
    localparam int H_MAX     = 308;
    localparam int V_MAX     = 261;
    localparam int SPRITE_W  = 8;
    localparam int SPRITE_H  = 16;
    localparam int COORD_W   = 9;
    localparam int IDX_W     = 3;
    localparam int ROW_W     = 4;
    localparam int ADDR_W    = IDX_W + ROW_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_LATCH = 2'd2
    } sched_state_t;
endpackage

// File: rtl/sprite_line_scheduler_pixel_mux.sv
// Per-sprite horizontal hit test and bit select, then a lowest-index-wins
// priority encode. Purely combinational; the top registers the result.
module sprite_pixel_mux #(
    parameter int NUM_SPRITES = 4,
    parameter int H_DISPLAY   = 256,
    parameter int V_MAX       = 261
) (
    input  logic [8:0]                   i_hpos,
    input  logic [8:0]                   i_vpos,
    input  logic [9*NUM_SPRITES-1:0]     i_sprite_x,
    input  logic [NUM_SPRITES-1:0]       i_active,
    input  logic [NUM_SPRITES-1:0][7:0]  i_rows,
    output logic                         o_hit,
    output logic [2:0]                   o_idx
);
    import sprite_line_scheduler_pkg::*;

    localparam logic [COORD_W-1:0] L_HD = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] L_VM = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] L_SW = COORD_W'(SPRITE_W);

    logic                   w_in_disp;
    logic [NUM_SPRITES-1:0] w_lit;

    // Blanking suppression keeps rows rewritten during hblank off the screen.
    assign w_in_disp = (i_hpos < L_HD) && (i_vpos <= L_VM);

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_lane
        logic [COORD_W-1:0] w_dx;
        assign w_dx     = i_hpos - i_sprite_x[COORD_W*k +: COORD_W];
        assign w_lit[k] = i_active[k] && (w_dx < L_SW) && w_in_disp &&
                          i_rows[k][3'd7 - w_dx[2:0]];
    end

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (w_lit[k]) begin
                o_hit = 1'b1;
                o_idx = 3'(k);
            end
        end
    end
endmodule

// File: rtl/sprite_line_scheduler.sv
// Fetches one bitmap row per sprite visible on the next line during hblank,
// then serialises the rows into a registered pixel/priority output.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_H    = sprite_line_scheduler_pkg::SPRITE_H,
    parameter int H_DISPLAY   = sprite_line_scheduler_pkg::H_DISPLAY,
    parameter int V_MAX       = sprite_line_scheduler_pkg::V_MAX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               hpos,
    input  logic [8:0]               vpos,
    input  logic [9*NUM_SPRITES-1:0] sprite_x,
    input  logic [9*NUM_SPRITES-1:0] sprite_y,
    output logic                     rom_en,
    output logic [6:0]               rom_addr,
    input  logic [7:0]               rom_data,
    output logic                     busy,
    output logic                     pix_on,
    output logic [2:0]               pix_idx
);
    import sprite_line_scheduler_pkg::*;

    localparam logic [COORD_W-1:0] L_HD   = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] L_VM   = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] L_SH   = COORD_W'(SPRITE_H);
    localparam logic [IDX_W-1:0]   L_LAST = IDX_W'(NUM_SPRITES - 1);

    sched_state_t                r_state, w_state_nxt;
    logic [IDX_W-1:0]            r_idx, w_idx_nxt;
    logic                        w_start, w_fetch, w_latch, w_last;
    logic [COORD_W-1:0]          w_tgt, w_dy;
    logic [COORD_W-1:0]          w_sy [8];
    logic [NUM_SPRITES-1:0]      r_active;
    logic [NUM_SPRITES-1:0][7:0] r_rows;
    logic                        r_rom_en;
    logic [ADDR_W-1:0]           r_rom_addr;
    logic                        w_hit;
    logic [2:0]                  w_win;
    logic                        r_pix_on;
    logic [2:0]                  r_pix_idx;

    // Padded to the full index space so r_idx selects without width games.
    for (genvar k = 0; k < 8; k++) begin : g_sy
        if (k < NUM_SPRITES) begin : g_on
            assign w_sy[k] = sprite_y[COORD_W*k +: COORD_W];
        end else begin : g_off
            assign w_sy[k] = '0;
        end
    end

    assign w_tgt  = (vpos == L_VM) ? '0 : vpos + 9'd1;
    assign w_dy   = w_tgt - w_sy[r_idx];
    assign w_last = (r_idx == L_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_start     = 1'b0;
        w_fetch     = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (hpos == L_HD) begin
                    w_start     = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_dy < L_SH) begin
                    w_fetch     = 1'b1;
                    w_state_nxt = S_LATCH;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            S_LATCH: begin
                w_latch = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = S_CHECK;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= '0;
            r_active   <= '0;
            r_rows     <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_rom_en <= w_fetch;
            if (w_fetch) r_rom_addr <= {r_idx, w_dy[ROW_W-1:0]};
            if (w_start) r_active <= '0;
            // rom_data answers the address issued in the preceding CHECK cycle.
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (w_latch && (r_idx == IDX_W'(k))) begin
                    r_rows[k]   <= rom_data;
                    r_active[k] <= 1'b1;
                end
            end
        end
    end

    sprite_pixel_mux #(
        .NUM_SPRITES (NUM_SPRITES),
        .H_DISPLAY   (H_DISPLAY),
        .V_MAX       (V_MAX)
    ) u_mux (
        .i_hpos     (hpos),
        .i_vpos     (vpos),
        .i_sprite_x (sprite_x),
        .i_active   (r_active),
        .i_rows     (r_rows),
        .o_hit      (w_hit),
        .o_idx      (w_win)
    );

    // pix_idx keeps the last winner while nothing is lit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_on  <= 1'b0;
            r_pix_idx <= '0;
        end else begin
            r_pix_on <= w_hit;
            if (w_hit) r_pix_idx <= w_win;
        end
    end

    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign busy     = (r_state != S_IDLE);
    assign pix_on   = r_pix_on;
    assign pix_idx  = r_pix_idx;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench: a line-level model predicts ROM fetches, busy length and
// pixels; a monitor process pops and compares as the DUT produces them.
module tb_sprite_line_scheduler;
    localparam int NS = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [8:0]      hpos = '0, vpos = '0;
    logic [9*NS-1:0] sprite_x = '0, sprite_y = '0;
    logic            rom_en, busy, pix_on;
    logic [6:0]      rom_addr;
    logic [7:0]      rom_data;
    logic [2:0]      pix_idx;
    logic [7:0]      rom [128];

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    sprite_line_scheduler #(.NUM_SPRITES(NS)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .pix_on(pix_on), .pix_idx(pix_idx)
    );

    int         vectors = 0, errors = 0;
    int         sx [NS], sy [NS];
    bit         m_act [NS];
    logic [7:0] m_row [NS];
    int         m_idx = 0;
    logic [3:0] pix_q [$];
    logic [6:0] rom_q [$];
    int         busy_q [$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input int v);
        return (v == 261) ? 0 : v + 1;
    endfunction

    function automatic int off_y(input int v);
        return (tgt_of(v) + 100) % 512;
    endfunction

    // Expected registered pixel after the edge that samples (h, v).
    task automatic push_pix(input int h, input int v);
        int win = -1;
        for (int k = 0; k < NS; k++) begin
            int dx = (h - sx[k]) & 511;
            if (win < 0 && m_act[k] && dx < 8 && h < 256 && v <= 261 && m_row[k][7-dx] == 1'b1)
                win = k;
        end
        if (win >= 0) m_idx = win;
        pix_q.push_back({(win >= 0), 3'(m_idx)});
    endtask

    task automatic model_fetch(input int v);
        int t = tgt_of(v);
        int vis = 0;
        for (int k = 0; k < NS; k++) m_act[k] = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int dy = (t - sy[k]) & 511;
            if (dy < 16) begin
                rom_q.push_back(7'(k*16 + dy));
                m_row[k] = rom[k*16 + dy];
                m_act[k] = 1'b1;
                vis++;
            end
        end
        // One CHECK per sprite plus one LATCH per fetched row.
        busy_q.push_back(NS + vis);
    endtask

    task automatic run_line(input int v, input int rst_h = -1);
        for (int k = 0; k < NS; k++) begin
            sprite_x[9*k +: 9] = 9'(sx[k]);
            sprite_y[9*k +: 9] = 9'(sy[k]);
        end
        for (int h = 0; h <= 308; h++) begin
            @(negedge clk);
            reset = 1'b1;
            hpos  = 9'(h);
            vpos  = 9'(v);
            if (h == rst_h) begin
                #1 reset = 1'b0;
                #1;
                chk("rst_async_rom_en", rom_en, 0);
                chk("rst_async_rom_addr", rom_addr, 0);
                chk("rst_async_busy", busy, 0);
                chk("rst_async_pix_on", pix_on, 0);
                chk("rst_async_pix_idx", pix_idx, 0);
                pix_q.delete();
                rom_q.delete();
                busy_q.delete();
                for (int k = 0; k < NS; k++) begin
                    m_act[k] = 1'b0;
                    m_row[k] = '0;
                end
                m_idx = 0;
                pix_q.push_back(4'h0);
            end else begin
                push_pix(h, v);
                if (h == 256) model_fetch(v);
            end
        end
        chk("rom_fetches_drained", rom_q.size(), 0);
        chk("busy_windows_drained", busy_q.size(), 0);
    endtask

    task automatic all_off(input int v);
        for (int k = 0; k < NS; k++) begin
            sy[k] = off_y(v);
            sx[k] = int'($urandom_range(0, 300));
        end
    endtask

    initial begin : monitor
        int         bcnt;
        logic [3:0] e;
        bcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (pix_q.size() > 0) begin
                e = pix_q.pop_front();
                chk("pix_on", pix_on, e[3]);
                chk("pix_idx", pix_idx, e[2:0]);
            end
            if (!reset) begin
                bcnt = 0;
            end else begin
                if (rom_en) begin
                    if (rom_q.size() == 0) chk("rom_en_unexpected", rom_en, 0);
                    else                   chk("rom_addr", rom_addr, rom_q.pop_front());
                end
                if (busy) begin
                    bcnt++;
                end else if (bcnt > 0) begin
                    if (busy_q.size() == 0) chk("busy_unexpected", bcnt, 0);
                    else                    chk("busy_cycles", bcnt, busy_q.pop_front());
                    bcnt = 0;
                end
            end
        end
    end

    initial begin : stim
        int v, t;
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        rom[0]  = 8'hA5;
        rom[16] = 8'hFF;
        for (int k = 0; k < NS; k++) begin
            sx[k] = 0; sy[k] = 300; m_act[k] = 1'b0; m_row[k] = '0;
        end

        #1;
        chk("reset_rom_en", rom_en, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pix_on", pix_on, 0);
        chk("reset_pix_idx", pix_idx, 0);
        repeat (3) @(negedge clk);

        // Single sprite, row A5 shown on line 50.
        all_off(49); sx[0] = 100; sy[0] = 50;
        run_line(49); run_line(50);

        // Overlapping sprites 0 and 2; lower index wins.
        all_off(9); sx[0] = 40; sy[0] = 10; sx[2] = 40; sy[2] = 10; sx[1] = 40;
        run_line(9); run_line(10);

        // Modular dy: no fetch at dy=257, row 4 for y=510 on target line 2.
        all_off(261); sy[0] = 255;
        run_line(261);
        all_off(1); sy[0] = 510; sx[0] = 60;
        run_line(1); run_line(2);

        // Sprite straddling the right edge of the display.
        all_off(99); sx[1] = 252; sy[1] = 100;
        run_line(99); run_line(100);

        // Every sprite visible: longest fetch.
        for (int k = 0; k < NS; k++) begin sx[k] = 20 * k; sy[k] = 121 - k; end
        run_line(120); run_line(121);

        // Reset during the LATCH for sprite 1, then recovery.
        for (int k = 0; k < NS; k++) begin sx[k] = 30 * k; sy[k] = 131 - k; end
        run_line(130, 260); run_line(131); run_line(132);

        for (int n = 0; n < 40; n++) begin
            v = ($urandom_range(0, 9) == 0) ? 261 : int'($urandom_range(0, 260));
            t = tgt_of(v);
            for (int k = 0; k < NS; k++) begin
                case ($urandom_range(0, 3))
                    0: sy[k] = (t - int'($urandom_range(0, 15))) & 511;
                    1: sy[k] = int'($urandom_range(0, 511));
                    2: sy[k] = (t - 16 - int'($urandom_range(0, 2))) & 511;
                    default: sy[k] = (t + 1) & 511;
                endcase
                sx[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 260))
                                                    : int'($urandom_range(0, 300));
            end
            run_line(v);
        end

        repeat (3) @(negedge clk);
        chk("pixel_queue_drained", pix_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Sequences the shared sprite-bitmap ROM for up to NUM_SPRITES hardware sprites, one scanline ahead of the beam.
- Takes hpos/vpos from the sync generator. At the start of each horizontal blank it scans the sprite table and fetches one 8-pixel bitmap row per sprite visible on the next line.
- During the next line's display period it serialises those rows into a registered pixel/priority output for the top-level colour mux.

Parameters:
- NUM_SPRITES, 4, sprites arbitrated for the single ROM port; legal range 1..8.
- SPRITE_H, 16, sprite height in lines; fixed at 16, matching the 4-bit row field of rom_addr.
- H_DISPLAY, 256, first hblank hpos value (fetch trigger).
- H_MAX, 308, last hpos of a line.
- V_MAX, 261, last vpos of a frame.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  9  beam column from the sync generator
- vpos  in  9  beam line from the sync generator
- sprite_x  in  9*NUM_SPRITES  left column per sprite; sprite k occupies bits [9k+8:9k]
- sprite_y  in  9*NUM_SPRITES  top line per sprite, same packing as sprite_x
- rom_en  out  1  ROM read strobe
- rom_addr  out  7  {idx[2:0], row[3:0]}
- rom_data  in  8  bitmap row; valid exactly 1 cycle after rom_en; bit 7 is the leftmost pixel
- busy  out  1  scheduler not in IDLE
- pix_on  out  1  a sprite pixel is lit at the current beam position
- pix_idx  out  3  index of the winning sprite

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, idx=0.
  - All row registers cleared to 0 and all active flags cleared.
  - rom_en=0, rom_addr=0, busy=0, pix_on=0, pix_idx=0.
- Target line: tgt = (vpos==V_MAX) ? 0 : vpos+1.
- FSM (all transitions on a clk edge):
  - IDLE: when hpos==H_DISPLAY, set idx=0, clear all active flags, go to CHECK. Otherwise stay.
  - CHECK: dy = (tgt - sprite_y[idx]) mod 512, 9-bit arithmetic.
    - If dy < SPRITE_H: rom_en=1 and rom_addr={idx, dy[3:0]} registered this cycle, go to LATCH.
    - Else if idx==NUM_SPRITES-1, go to IDLE.
    - Else idx+1, stay in CHECK.
  - LATCH: row[idx] <= rom_data and active[idx] <= 1. rom_en returns to 0.
    - If idx==NUM_SPRITES-1, go to IDLE.
    - Else idx+1, go to CHECK.
- ROM read timing: rom_en is high for exactly one cycle per visible sprite. rom_addr holds its value until the next fetch.
- Worst-case fetch time is 2*NUM_SPRITES+1 cycles, i.e. 17 at 8 sprites. This is well inside the 53-cycle hblank, so fetching always finishes before hpos wraps.
- Sprite attributes are sampled only in CHECK. Changing sprite_x/sprite_y mid-line takes effect on the following fetch.
- Wrap-around: a sprite with sprite_y > tgt uses modular dy. Example: sprite_y=510, tgt=2 gives dy=4, so row 4 is shown.
- Render (compute every cycle, register the result; 1-cycle latency):
  - For each k, dx = hpos - sprite_x[k] (9-bit).
  - Sprite k is lit if active[k], dx<8, hpos<H_DISPLAY and vpos<=V_MAX, and row[k][7-dx]==1.
  - Lowest lit index wins. pix_on and pix_idx are registered from the winner.
  - When no sprite is lit: pix_on=0 and pix_idx holds its previous value.
  - Pixels with hpos>=H_DISPLAY are suppressed, so rows overwritten during hblank never glitch the display.
- If reset is asserted mid-fetch, the FSM aborts to IDLE and that line shows no sprites. Fetching resumes at the next hpos==H_DISPLAY.
- hpos==H_DISPLAY while not IDLE: ignored (unreachable with legal timing).

Decomposition:
- Shared package holds:
  - the video timing constants (H_DISPLAY, H_MAX, V_MAX);
  - the state encoding (IDLE=0, CHECK=1, LATCH=2);
  - SPRITE_W=8 and the rom_addr field widths.
- One natural sub-module: sprite_pixel_mux, the per-sprite dx compare, bit select and priority encode. The scheduler FSM stays in the top module.

Test Plan:
1. Sprite 0 at x=100, y=50, ROM row 0 = 8'hA5; beam at vpos=49, hpos=256.
   - rom_en pulses next cycle with rom_addr=7'h00.
   - On line 50, pix_on at hpos 100..107 (one cycle late) = 1,0,1,0,0,1,0,1 with pix_idx=0.
2. Sprites 0 and 2 overlap at x=40, y=10; sprite 1 off-line.
   - Exactly two rom_en pulses, addrs {0,dy} and {2,dy}; busy high for 6 cycles.
   - Overlapping lit pixels report pix_idx=0.
3. sprite_y=255 at vpos=261 (tgt=0): dy=257 → no fetch.
   - sprite_y=510 at tgt=2: rom_addr row field=4.
4. Sprite at x=252, row 8'hFF: pixels 252..255 lit; hpos 256..259 give pix_on=0.
5. Assert reset low in the LATCH state during the fetch for sprite 1.
   - All outputs 0 immediately (asynchronously), state IDLE.
   - After release, the line shows no sprites; the next hblank fetches normally.
6. NUM_SPRITES=8, all visible: 8 rom_en pulses; busy falls 17 cycles after hpos=256, before hpos reaches 308.
